// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared types and constants for the serial shift transmitter/receiver pair
package shift_pkg;

    // Word size shared by the load-and-shift transmitter and this receiver.
    localparam int DEFAULT_WIDTH = 8;

    // Receiver frame FSM: IDLE has no partial word, SHIFT holds bit_cnt bits.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } deser_state_t;

    // Bit counter must represent 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/deser_hold_reg.sv
// rtl/deser_hold_reg.sv - valid/ready output holding register with dropped-word detect
import shift_pkg::*;

module deser_hold_reg #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_word,
    input  logic             i_word_done,
    input  logic             i_data_ready,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_data_valid,
    output logic             o_drop
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             w_xfer;
    logic             w_load;

    // A completed word only has room if the register is empty or being drained now.
    assign w_xfer = r_valid && i_data_ready;
    assign w_load = i_word_done && (!r_valid || i_data_ready);
    assign o_drop = i_word_done && r_valid && !i_data_ready;

    // Load new words, clear valid on a transfer that is not refilled the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_data  <= i_word;
            r_valid <= 1'b1;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data_out   = r_data;
    assign o_data_valid = r_valid;

endmodule

// File: rtl/shift_deserializer.sv
// rtl/shift_deserializer.sv - serial-to-parallel receiver with overrun and framing flags
import shift_pkg::*;

module shift_deserializer #(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_serial_in,
    input  logic             i_bit_en,
    input  logic             i_frame_start,
    output logic [WIDTH-1:0] o_data_out,
    output logic             o_data_valid,
    input  logic             i_data_ready,
    output logic             o_overrun,
    output logic             o_frame_err,
    input  logic             i_clear_err
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    deser_state_t     r_state;
    deser_state_t     w_nxt_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] w_nxt_sr;
    logic [WIDTH-1:0] w_shifted;
    logic             w_word_done;
    logic             w_frame_evt;
    logic             w_drop;
    logic             r_overrun;
    logic             r_frame_err;

    // Shift register contents with the current line bit folded in; also the completed word.
    always_comb begin
        w_shifted = r_sr;
        if (LSB_FIRST) begin
            w_shifted = {i_serial_in, r_sr[WIDTH-1:1]};
        end else begin
            w_shifted = {r_sr[WIDTH-2:0], i_serial_in};
        end
    end

    // Frame FSM: next state, counter, shift register and completion/framing events.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_bit_cnt;
        w_nxt_sr    = r_sr;
        w_word_done = 1'b0;
        w_frame_evt = 1'b0;
        case (r_state)
            IDLE: begin
                // Bits outside a frame are discarded until a frame_start arrives.
                if (i_bit_en && i_frame_start) begin
                    w_nxt_sr    = w_shifted;
                    w_nxt_cnt   = CNT_W'(1);
                    w_nxt_state = SHIFT;
                end
            end
            SHIFT: begin
                if (i_bit_en) begin
                    w_nxt_sr = w_shifted;
                    if (i_frame_start) begin
                        // Early restart: the partial word is abandoned, this bit is bit 0.
                        w_frame_evt = 1'b1;
                        w_nxt_cnt   = CNT_W'(1);
                    end else if (r_bit_cnt == LAST_CNT) begin
                        w_word_done = 1'b1;
                        w_nxt_cnt   = '0;
                        w_nxt_state = IDLE;
                    end else begin
                        w_nxt_cnt = r_bit_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // FSM state, bit counter and shift register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_sr      <= '0;
        end else begin
            r_state   <= w_nxt_state;
            r_bit_cnt <= w_nxt_cnt;
            r_sr      <= w_nxt_sr;
        end
    end

    deser_hold_reg #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk         (clk),
        .rst         (rst),
        .i_word      (w_shifted),
        .i_word_done (w_word_done),
        .i_data_ready(i_data_ready),
        .o_data_out  (o_data_out),
        .o_data_valid(o_data_valid),
        .o_drop      (w_drop)
    );

    // Sticky error flags; a new event in the same cycle as clear_err keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= w_drop      || (r_overrun   && !i_clear_err);
            r_frame_err <= w_frame_evt || (r_frame_err && !i_clear_err);
        end
    end

    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_shift_deserializer.sv
// tb/tb_shift_deserializer.sv - directed self-checking bench for shift_deserializer
module tb_shift_deserializer;

    logic       clk;
    logic       rst;
    logic       serial_in, bit_en, frame_start, data_ready, clear_err;
    logic [7:0] data_out;
    logic       data_valid, overrun, frame_err;

    logic       rst_b;
    logic       serial_in_b, bit_en_b, frame_start_b, data_ready_b, clear_err_b;
    logic [3:0] data_out_b;
    logic       data_valid_b, overrun_b, frame_err_b;

    int n_checks = 0;
    int n_fail   = 0;

    shift_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_serial_in  (serial_in),
        .i_bit_en     (bit_en),
        .i_frame_start(frame_start),
        .o_data_out   (data_out),
        .o_data_valid (data_valid),
        .i_data_ready (data_ready),
        .o_overrun    (overrun),
        .o_frame_err  (frame_err),
        .i_clear_err  (clear_err)
    );

    shift_deserializer #(.WIDTH(4), .LSB_FIRST(1'b0)) dut_b (
        .clk          (clk),
        .rst          (rst_b),
        .i_serial_in  (serial_in_b),
        .i_bit_en     (bit_en_b),
        .i_frame_start(frame_start_b),
        .o_data_out   (data_out_b),
        .o_data_valid (data_valid_b),
        .i_data_ready (data_ready_b),
        .o_overrun    (overrun_b),
        .o_frame_err  (frame_err_b),
        .i_clear_err  (clear_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Drive one 8-bit word LSB first; returns right after presenting the last bit.
    task automatic send_a(input logic [7:0] w, input bit gap);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bit_en      = 1'b1;
            serial_in   = w[i];
            frame_start = (i == 0);
            if (gap && i < 7) begin
                @(negedge clk);
                bit_en      = 1'b0;
                frame_start = 1'b0;
            end
        end
    endtask

    task automatic idle_a();
        @(negedge clk);
        bit_en      = 1'b0;
        frame_start = 1'b0;
        serial_in   = 1'b0;
    endtask

    task automatic bit_b(input logic b, input logic fs);
        @(negedge clk);
        bit_en_b      = 1'b1;
        serial_in_b   = b;
        frame_start_b = fs;
    endtask

    task automatic idle_b();
        @(negedge clk);
        bit_en_b      = 1'b0;
        frame_start_b = 1'b0;
        serial_in_b   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; serial_in = 0; bit_en = 0; frame_start = 0; data_ready = 0; clear_err = 0;
        rst_b = 1'b1; serial_in_b = 0; bit_en_b = 0; frame_start_b = 0; data_ready_b = 1; clear_err_b = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0; rst_b = 1'b0;
        @(negedge clk);

        check_eq("reset_data_out", 32'(data_out), 32'h0);
        check_eq("reset_valid", 32'(data_valid), 32'h0);
        check_eq("reset_overrun", 32'(overrun), 32'h0);
        check_eq("reset_frame_err", 32'(frame_err), 32'h0);

        // Bits with no frame_start are ignored.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_en = 1'b1; serial_in = 1'b1; frame_start = 1'b0;
        end
        idle_a();
        check_eq("idle_valid", 32'(data_valid), 32'h0);
        check_eq("idle_bit_cnt", 32'(dut.r_bit_cnt), 32'h0);

        // LSB-first 8'hA5, consumer ready.
        data_ready = 1'b1;
        send_a(8'hA5, 1'b0);
        check_eq("a5_not_early", 32'(data_valid), 32'h0);
        idle_a();
        check_eq("a5_valid", 32'(data_valid), 32'h1);
        check_eq("a5_data", 32'(data_out), 32'hA5);
        @(negedge clk);
        check_eq("a5_one_cycle", 32'(data_valid), 32'h0);

        // Gapped 8'h3C under back-pressure.
        data_ready = 1'b0;
        send_a(8'h3C, 1'b1);
        idle_a();
        check_eq("3c_valid", 32'(data_valid), 32'h1);
        check_eq("3c_data", 32'(data_out), 32'h3C);
        repeat (3) @(negedge clk);
        check_eq("3c_held_valid", 32'(data_valid), 32'h1);
        check_eq("3c_held_data", 32'(data_out), 32'h3C);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        check_eq("3c_drained", 32'(data_valid), 32'h0);

        // Overrun: 8'h22 completes while 8'h11 is still pending.
        send_a(8'h11, 1'b0);
        idle_a();
        check_eq("ovr_first_data", 32'(data_out), 32'h11);
        check_eq("ovr_flag_before", 32'(overrun), 32'h0);
        send_a(8'h22, 1'b0);
        idle_a();
        check_eq("ovr_kept_data", 32'(data_out), 32'h11);
        check_eq("ovr_valid", 32'(data_valid), 32'h1);
        check_eq("ovr_flag", 32'(overrun), 32'h1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("ovr_cleared", 32'(overrun), 32'h0);
        data_ready = 1'b1;
        @(negedge clk);
        check_eq("ovr_drained", 32'(data_valid), 32'h0);

        // Framing error: restart after 3 bits, then 8'hF0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bit_en = 1'b1; serial_in = 1'b1; frame_start = (i == 0);
        end
        send_a(8'hF0, 1'b0);
        idle_a();
        check_eq("fe_flag", 32'(frame_err), 32'h1);
        check_eq("fe_data", 32'(data_out), 32'hF0);
        check_eq("fe_valid", 32'(data_valid), 32'h1);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
        check_eq("fe_cleared", 32'(frame_err), 32'h0);

        // Set wins over clear: overrun occurs while clear_err is held.
        data_ready = 1'b0;
        send_a(8'h55, 1'b0);
        idle_a();
        clear_err = 1'b1;
        send_a(8'h66, 1'b0);
        idle_a();
        clear_err = 1'b0;
        check_eq("setwins_overrun", 32'(overrun), 32'h1);
        check_eq("setwins_data", 32'(data_out), 32'h55);
        data_ready = 1'b1;
        @(negedge clk);

        // MSB-first, WIDTH=4: bits 1,1,0,0 -> 4'hC.
        bit_b(1'b1, 1'b1);
        bit_b(1'b1, 1'b0);
        bit_b(1'b0, 1'b0);
        bit_b(1'b0, 1'b0);
        check_eq("b_not_early", 32'(data_valid_b), 32'h0);
        idle_b();
        check_eq("b_valid", 32'(data_valid_b), 32'h1);
        check_eq("b_data", 32'(data_out_b), 32'hC);
        @(negedge clk);
        check_eq("b_drained", 32'(data_valid_b), 32'h0);

        // Reset mid-word: no output, no flags.
        data_ready_b = 1'b0;
        bit_b(1'b1, 1'b1);
        bit_b(1'b0, 1'b0);
        bit_b(1'b1, 1'b0);
        rst_b = 1'b1;
        bit_b(1'b1, 1'b0);
        rst_b = 1'b0;
        idle_b();
        repeat (2) @(negedge clk);
        check_eq("b_rst_valid", 32'(data_valid_b), 32'h0);
        check_eq("b_rst_data", 32'(data_out_b), 32'h0);
        check_eq("b_rst_overrun", 32'(overrun_b), 32'h0);
        check_eq("b_rst_frame_err", 32'(frame_err_b), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-to-parallel receiver that complements the team's 8-bit load-and-shift transmitter. Samples one bit per qualified clock from `serial_in`, LSB first by default, assembles `WIDTH`-bit words and presents each completed word on a registered valid/ready output. It sits on the receive side of the serial link between the line and the consuming logic. It flags words lost to back-pressure and frames broken by an early restart.

## Interface
Parameters:
- `WIDTH`, 8: word size in bits; must be at least 2.
- `LSB_FIRST`, 1: 1 means the first received bit lands in bit 0; 0 means it lands in bit `WIDTH-1`.

Ports (reset `rst`, synchronous, active-high; clock `clk`):
- `clk`  in  1: clock. All logic updates on the rising edge.
- `rst`  in  1: synchronous active-high reset.
- `serial_in`  in  1: serial data bit.
- `bit_en`  in  1: `serial_in` holds a valid bit this cycle.
- `frame_start`  in  1: this bit is bit 0 of a new word. Ignored unless `bit_en` is high.
- `data_out`  out  WIDTH: last completed word. Held while `data_valid` is high.
- `data_valid`  out  1: `data_out` is pending for the consumer.
- `data_ready`  in  1: consumer accepts the word. A transfer occurs when `data_valid && data_ready`.
- `overrun`  out  1: sticky. A completed word was dropped.
- `frame_err`  out  1: sticky. `frame_start` arrived mid-word.
- `clear_err`  in  1: clears both sticky flags next edge.

## Operation
- FSM states:
  - IDLE: no word in progress.
  - SHIFT: partial word held; `bit_cnt` runs 1..WIDTH-1.
- IDLE:
  - `bit_en && frame_start`: capture the bit, set `bit_cnt`=1, go to SHIFT.
  - `bit_en` without `frame_start`: the bit is discarded; stay in IDLE.
- SHIFT, `bit_en && !frame_start`:
  - Capture the bit and increment `bit_cnt`.
  - On the WIDTH-th bit, complete the word and return to IDLE with `bit_cnt`=0.
- SHIFT, `bit_en && frame_start`:
  - Discard the partial word and set `frame_err`.
  - Restart with this bit as bit 0; `bit_cnt`=1; stay in SHIFT.
- Shift direction:
  - `LSB_FIRST`=1: `sr <= {serial_in, sr[WIDTH-1:1]}`.
  - `LSB_FIRST`=0: `sr <= {sr[WIDTH-2:0], serial_in}`.
  - For the completing bit, the full word is formed from `sr` plus `serial_in` in the same way. No extra cycle is spent.
- Output holding register on completion:
  - `data_valid`=0, or `data_valid && data_ready`: load the word and set `data_valid`=1.
  - Otherwise: drop the new word, keep the old `data_out`, and set `overrun`.
- `data_valid` clears on `data_valid && data_ready` unless a new word loads in that same cycle.
- `bit_en` low: no change to `sr`, `bit_cnt` or state. Gaps between bits of any length are legal.
- Sticky flags:
  - `clear_err` and a new error event in the same cycle: the flag ends up set (set wins).
  - `clear_err` does not affect the datapath.

## Timing
- Reset values:
  - `data_out`=0, `data_valid`=0, `overrun`=0, `frame_err`=0.
  - State IDLE, `bit_cnt`=0, `sr`=0.
- Reset mid-word discards the partial word and any pending output. No flags are set.
- Latency: `data_valid` rises in the cycle after the edge that samples the last bit. That is 1 clock after the last bit is presented.
- Throughput: one bit per clock with `bit_en` held high. Back-to-back words need `frame_start` on every word's bit 0.
- Transmitter link: the transmitter's `data_out` is valid from the cycle after `load`. Drive `frame_start`/`bit_en` from `load` delayed by 1 cycle, then hold `bit_en` for WIDTH cycles.
- All outputs are registered. No combinational path from inputs to outputs.

## Structure
- Shared package `shift_pkg`:
  - FSM state typedef {IDLE, SHIFT}.
  - Counter width constant `$clog2(WIDTH+1)`.
  - Default `WIDTH`=8, shared with the transmitter.
- One sub-module is natural: `deser_hold_reg`. It is the valid/ready output register with the overrun detect. Inputs: word, `word_done`, `data_ready`, `clk`, `rst`.
- The FSM, counter and shift register stay in the top module.

## Test plan
- Reset then idle: after reset, all outputs are 0. `bit_en` pulses without `frame_start` -> `data_valid` stays 0 and `bit_cnt` stays 0.
- LSB-first word: `frame_start` then bits 1,0,1,0,0,1,0,1 on consecutive cycles, `data_ready`=1 -> `data_out`=8'hA5, `data_valid` high exactly 1 cycle, 1 clock after the 8th bit.
- Gapped bits and back-pressure: word 8'h3C sent with `bit_en` low every other cycle, `data_ready`=0 -> `data_valid` holds with 8'h3C. Raise `data_ready` -> `data_valid` drops the next cycle.
- Overrun: 8'h11 pending (`data_ready`=0), then 8'h22 completes -> `data_out` stays 8'h11 and `overrun`=1. `clear_err` -> `overrun`=0 the next cycle.
- Framing error: `frame_start` again after 3 bits, then 8 bits forming 8'hF0 -> `frame_err`=1 and `data_out`=8'hF0.
- `LSB_FIRST`=0 with `WIDTH`=4: bits 1,1,0,0 -> `data_out`=4'hC. Also apply reset at bit 2 of a word -> no output and no flags.
